isa_bus_arbiter: RTL and testbench

- Shares the ISA bus between host PIO cycles and four DMA channels: DRQ1/3/5/7 in, DACK1/3/5/7 and AEN out.
- Synchronises the asynchronous DRQ lines and picks one owner per tenure, using round-robin among channels.
- Sequences the AEN/DACK setup and release edges and hands a one-hot grant to the DMA datapath.
- Sits between the Avalon-facing ISA bridge logic and the ISA pins of the SoC top.

---
 rtl/isa_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_isa_bus_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_bus_arbiter.sv
// ISA bus arbiter: host PIO cycles versus four round-robin DMA channels.
// Sequences the AEN/DACK setup and release edges around each DMA tenure.
module isa_bus_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_BURST   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] drq_in,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              host_req,
    input  logic              host_done,
    input  logic              dma_xfer_done,
    input  logic              dma_tc,
    output logic              host_gnt,
    output logic [NUM_CH-1:0] dma_grant,
    output logic [NUM_CH-1:0] dack_n,
    output logic              aen,
    output logic              busy
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE,
        HOST,
        DMA_SETUP,
        DMA_ACTIVE,
        DMA_RELEASE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NUM_CH-1:0] sync_q [SS];
    logic [NUM_CH-1:0] drq_s;
    logic [NUM_CH-1:0] eligible;
    logic [CW-1:0]     cur;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     next_ptr;
    logic [CW-1:0]     pick;
    logic [CW-1:0]     idx;
    logic              found;
    logic [BW-1:0]     burst_cnt;
    logic              burst_hit;
    logic              end_tenure;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SS; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= drq_in;
            for (int i = 1; i < SS; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign drq_s    = sync_q[SS-1];
    assign eligible = drq_s & ch_enable;

    // First eligible channel at or above rr_ptr, wrapping around.
    always_comb begin
        pick  = rr_ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CW'((int'(rr_ptr) + k) % NUM_CH);
            if (!found && eligible[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign next_ptr  = (cur == CW'(NUM_CH - 1)) ? '0 : cur + 1'b1;
    assign burst_hit = (MAX_BURST != 0) && (int'(burst_cnt) + 1 == MAX_BURST);

    assign end_tenure = (dma_xfer_done && (dma_tc || !drq_s[cur] || burst_hit))
                     || !ch_enable[cur];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (host_req) begin
                    state_nxt = HOST;
                end else if (found) begin
                    state_nxt = DMA_SETUP;
                end
            end
            HOST: begin
                if (host_done) begin
                    state_nxt = IDLE;
                end
            end
            DMA_SETUP:   state_nxt = DMA_ACTIVE;
            DMA_ACTIVE: begin
                if (end_tenure) begin
                    state_nxt = DMA_RELEASE;
                end
            end
            DMA_RELEASE: state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && !host_req && found) begin
                cur       <= pick;
                burst_cnt <= '0;
            end
            if (state == DMA_ACTIVE && dma_xfer_done && burst_cnt != '1) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (state == DMA_RELEASE) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // AEN brackets the whole tenure; DACK only in the active phase.
    always_comb begin
        host_gnt  = (state == HOST);
        aen       = (state == DMA_SETUP) || (state == DMA_ACTIVE)
                 || (state == DMA_RELEASE);
        busy      = (state != IDLE);
        dma_grant = '0;
        dack_n    = '1;
        if (state == DMA_SETUP || state == DMA_ACTIVE) begin
            dma_grant[cur] = 1'b1;
        end
        if (state == DMA_ACTIVE) begin
            dack_n[cur] = 1'b0;
        end
    end

endmodule

// File: tb/tb_isa_bus_arbiter.sv
// Bench for isa_bus_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_isa_bus_arbiter;

    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int MB  = 2;

    localparam int M_IDLE   = 0;
    localparam int M_HOST   = 1;
    localparam int M_SETUP  = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_REL    = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] drq_in;
    logic [NCH-1:0] ch_enable;
    logic           host_req;
    logic           host_done;
    logic           dma_xfer_done;
    logic           dma_tc;
    logic           host_gnt;
    logic [NCH-1:0] dma_grant;
    logic [NCH-1:0] dack_n;
    logic           aen;
    logic           busy;

    int errors = 0;
    int checks = 0;

    int             m_mode;
    int             m_owner;
    int             m_ptr;
    int             m_xfers;
    logic [NCH-1:0] dq [$];

    isa_bus_arbiter #(
        .NUM_CH(NCH),
        .SYNC_STAGES(SS),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .drq_in(drq_in),
        .ch_enable(ch_enable),
        .host_req(host_req),
        .host_done(host_done),
        .dma_xfer_done(dma_xfer_done),
        .dma_tc(dma_tc),
        .host_gnt(host_gnt),
        .dma_grant(dma_grant),
        .dack_n(dack_n),
        .aen(aen),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_owner = 0;
        m_ptr   = 0;
        m_xfers = 0;
        dq.delete();
        repeat (SS) dq.push_back('0);
    endtask

    // One clock edge of the reference arbiter, using the inputs now applied.
    task automatic model_edge();
        logic [NCH-1:0] ds;
        logic [NCH-1:0] elig;
        bit             stop;
        if (reset) begin
            model_reset();
            return;
        end
        ds = dq[0];
        void'(dq.pop_front());
        dq.push_back(drq_in);
        case (m_mode)
            M_IDLE: begin
                if (host_req) begin
                    m_mode = M_HOST;
                end else begin
                    elig = ds & ch_enable;
                    for (int k = 0; k < NCH; k++) begin
                        int c;
                        c = (m_ptr + k) % NCH;
                        if (elig[c]) begin
                            m_owner = c;
                            m_xfers = 0;
                            m_mode  = M_SETUP;
                            break;
                        end
                    end
                end
            end
            M_HOST:  if (host_done) m_mode = M_IDLE;
            M_SETUP: m_mode = M_ACTIVE;
            M_ACTIVE: begin
                stop = 0;
                if (dma_xfer_done) begin
                    m_xfers++;
                    if (dma_tc || !ds[m_owner] || m_xfers == MB) stop = 1;
                end
                if (!ch_enable[m_owner]) stop = 1;
                if (stop) m_mode = M_REL;
            end
            default: begin
                m_ptr  = (m_owner + 1) % NCH;
                m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [NCH-1:0] eg;
        logic [NCH-1:0] ed;
        eg = '0;
        ed = '1;
        if (m_mode == M_SETUP || m_mode == M_ACTIVE) eg[m_owner] = 1'b1;
        if (m_mode == M_ACTIVE) ed[m_owner] = 1'b0;
        chk("host_gnt", host_gnt, m_mode == M_HOST);
        chk("aen", aen, m_mode >= M_SETUP);
        chk("busy", busy, m_mode != M_IDLE);
        chk("dma_grant", dma_grant, eg);
        chk("dack_n", dack_n, ed);
        chk("inv_gnt_aen", host_gnt & aen, 0);
        chk("inv_one_dack", $countones(~dack_n) <= 1, 1);
        chk("inv_dack_aen", (dack_n != '1) && !aen, 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drain(input int n);
        host_req = 0;
        dma_tc   = 0;
        repeat (n) begin
            dma_xfer_done = (m_mode == M_ACTIVE);
            host_done     = (m_mode == M_HOST);
            cycle();
        end
        dma_xfer_done = 0;
        host_done     = 0;
    endtask

    task automatic wait_mode(input string tag, input int target, input int bound);
        for (int n = 0; n < bound && m_mode != target; n++) cycle();
        chk(tag, m_mode == target, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order [$];
        int xf [$];
        int cnt;
        reset         = 1;
        drq_in        = '1;
        ch_enable     = '1;
        host_req      = 1;
        host_done     = 0;
        dma_xfer_done = 0;
        dma_tc        = 0;
        model_reset();

        repeat (3) cycle();
        chk("rst_dack", dack_n, 4'hF);
        chk("rst_hgnt", host_gnt, 0);
        reset  = 0;
        drq_in = '0;
        cycle();
        chk("rst_host_lat", host_gnt, 1);
        host_req  = 0;
        host_done = 1;
        cycle();
        chk("host_done_idle", host_gnt, 0);
        host_done = 0;
        cycle();

        drq_in = 4'b0010;
        cycle();
        chk("sc_aen_c1", aen, 0);
        cycle();
        chk("sc_aen_c2", aen, 0);
        cycle();
        chk("sc_aen_c3", aen, 1);
        chk("sc_dack_setup", dack_n, 4'hF);
        cycle();
        chk("sc_dack", dack_n, 4'b1101);
        dma_xfer_done = 1;
        dma_tc        = 1;
        drq_in        = '0;
        cycle();
        dma_xfer_done = 0;
        dma_tc        = 0;
        chk("sc_rel_dack", dack_n, 4'hF);
        chk("sc_rel_aen", aen, 1);
        cycle();
        chk("sc_idle_aen", aen, 0);
        repeat (3) cycle();

        reset = 1;
        cycle();
        reset  = 0;
        drq_in = '1;
        cnt    = 0;
        for (int n = 0; n < 80 && order.size() < 6; n++) begin
            dma_xfer_done = (m_mode == M_ACTIVE);
            if (dma_xfer_done) cnt++;
            cycle();
            if (aen && dack_n == 4'hF && dma_grant != '0) begin
                for (int c = 0; c < NCH; c++) begin
                    if (dma_grant[c]) order.push_back(c);
                end
                if (order.size() > 1) xf.push_back(cnt);
                cnt = 0;
            end
        end
        chk("rr_tenures", order.size(), 6);
        if (order.size() == 6) begin
            for (int t = 0; t < 5; t++) begin
                chk("rr_order", order[t], t % NCH);
                chk("rr_burst", xf[t], MB);
            end
        end
        dma_xfer_done = 0;
        drq_in        = '0;
        drain(12);

        drq_in = 4'b0100;
        cycle();
        cycle();
        host_req = 1;
        cycle();
        chk("hp_host_first", host_gnt, 1);
        chk("hp_no_aen", aen, 0);
        host_req  = 0;
        host_done = 1;
        cycle();
        host_done = 0;
        chk("hp_idle", host_gnt, 0);
        cycle();
        chk("hp_ch2_setup", dma_grant, 4'b0100);
        drq_in = '0;
        drain(10);

        drq_in = 4'b0001;
        wait_mode("np_wait", M_ACTIVE, 10);
        host_req = 1;
        cycle();
        chk("np_hold", host_gnt, 0);
        chk("np_dack", dack_n, 4'b1110);
        dma_xfer_done = 1;
        dma_tc        = 1;
        drq_in        = '0;
        cycle();
        dma_xfer_done = 0;
        dma_tc        = 0;
        chk("np_rel", host_gnt, 0);
        cycle();
        chk("np_idle", host_gnt, 0);
        cycle();
        chk("np_host", host_gnt, 1);
        drain(6);

        drq_in = 4'b1000;
        wait_mode("dis_wait", M_ACTIVE, 10);
        ch_enable = 4'b0111;
        cycle();
        chk("dis_rel_dack", dack_n, 4'hF);
        chk("dis_rel_grant", dma_grant, 0);
        chk("dis_rel_aen", aen, 1);
        cycle();
        cycle();
        chk("dis_blocked", busy, 0);
        drq_in = '0;
        drain(5);
        ch_enable = '1;

        drq_in = 4'b0001;
        wait_mode("rst_mid_wait", M_ACTIVE, 10);
        reset = 1;
        cycle();
        chk("rst_mid_dack", dack_n, 4'hF);
        chk("rst_mid_aen", aen, 0);
        reset  = 0;
        drq_in = '0;
        drain(5);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(3) == 0) drq_in = 4'($urandom);
            ch_enable = ($urandom_range(15) == 0) ? 4'($urandom) : 4'hF;
            if (host_req && m_mode == M_HOST) host_req = 0;
            else if (!host_req && $urandom_range(9) == 0) host_req = 1;
            host_done     = (m_mode == M_HOST) && ($urandom_range(2) == 0);
            dma_xfer_done = (m_mode == M_ACTIVE) && ($urandom_range(1) == 1);
            dma_tc        = dma_xfer_done && ($urandom_range(3) == 0);
            reset         = ($urandom_range(199) == 0);
            cycle();
        end
        reset = 0;
        drq_in = '0;
        ch_enable = '1;
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
